dead_time_gen: RTL and testbench

- Downstream of the 3-level phase-shifted comparator stage.
- Takes the 6 raw switching commands (3 H-bridges × 2 legs) and produces complementary high-side/low-side gate pairs per leg.
- Inserts a programmable dead time so that both switches of a leg are never on together.
- Provides fault/enable blanking to the gate drivers.

---
 rtl/modhw_pkg.sv | 23 ++
 rtl/dt_leg.sv | 88 ++++++++
 rtl/dead_time_gen.sv | 72 +++++++
 tb/tb_dead_time_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/modhw_pkg.sv
// Shared types and constants for the dead-time generator: leg FSM encoding,
// default widths and the cmd bit mapping (bit 2k+j = bridge k+1, leg j).
package modhw_pkg;

  localparam int N_LEGS_DEF      = 6;
  localparam int DT_W_DEF        = 8;
  localparam int N_BRIDGES       = 3;
  localparam int LEGS_PER_BRIDGE = 2;

  typedef enum logic [2:0] {
    IDLE,
    DT_H,
    ON_H,
    DT_L,
    ON_L
  } leg_state_e;

  // Zero-based bridge and leg numbers to the cmd/gate bit position.
  function automatic int cmd_idx(input int bridge, input int leg);
    return bridge * LEGS_PER_BRIDGE + leg;
  endfunction

endpackage

// File: rtl/dt_leg.sv
// One half-bridge leg: complementary-switch FSM with a dead-time counter.
// Handshake-free block; blank overrides everything and parks the leg in IDLE.
module dt_leg
  import modhw_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            blank,
  input  logic            cmd,
  input  logic [DT_W-1:0] dt_load,
  output leg_state_e      state_o
);

  leg_state_e      state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // dt_load is only captured on window entry, so a window keeps its length.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (blank) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = cmd ? DT_H : DT_L;
          cnt_d   = dt_load;
        end
        DT_H: begin
          if (!cmd) begin
            state_d = DT_L;
            cnt_d   = dt_load;
          end else if (cnt_q <= DT_W'(1)) begin
            state_d = ON_H;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        ON_H: begin
          if (!cmd) begin
            state_d = DT_L;
            cnt_d   = dt_load;
          end
        end
        DT_L: begin
          if (cmd) begin
            state_d = DT_H;
            cnt_d   = dt_load;
          end else if (cnt_q <= DT_W'(1)) begin
            state_d = ON_L;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        ON_L: begin
          if (cmd) begin
            state_d = DT_H;
            cnt_d   = dt_load;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    state_o = state_q;
  end

endmodule

// File: rtl/dead_time_gen.sv
// Dead-time generator top: fault latch, blanking and N_LEGS independent legs.
// Gates are pure decodes of each leg's state register, so hi and lo never overlap.
module dead_time_gen
  import modhw_pkg::*;
#(
  parameter int N_LEGS = N_LEGS_DEF,
  parameter int DT_W   = DT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fault,
  input  logic              fault_clr,
  input  logic [DT_W-1:0]   dt_cycles,
  input  logic [N_LEGS-1:0] cmd,
  output logic [N_LEGS-1:0] gate_hi,
  output logic [N_LEGS-1:0] gate_lo,
  output logic              fault_latched
);

  logic            fault_latched_q, fault_latched_d;
  logic            blank;
  logic [DT_W-1:0] dt_load;
  leg_state_e      leg_state [N_LEGS];

  // A trip in the same cycle as a clear request keeps the flag set.
  always_comb begin
    fault_latched_d = fault_latched_q;
    if (fault) begin
      fault_latched_d = 1'b1;
    end else if (fault_clr) begin
      fault_latched_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_latched_q <= 1'b0;
    end else begin
      fault_latched_q <= fault_latched_d;
    end
  end

  always_comb begin
    blank   = rst | ~en | fault | fault_latched_q;
    dt_load = (dt_cycles == '0) ? DT_W'(1) : dt_cycles;
  end

  for (genvar k = 0; k < N_LEGS; k++) begin : g_leg
    dt_leg #(
      .DT_W(DT_W)
    ) u_leg (
      .clk    (clk),
      .rst    (rst),
      .blank  (blank),
      .cmd    (cmd[k]),
      .dt_load(dt_load),
      .state_o(leg_state[k])
    );
  end

  always_comb begin
    gate_hi = '0;
    gate_lo = '0;
    for (int k = 0; k < N_LEGS; k++) begin
      gate_hi[k] = (leg_state[k] == ON_H);
      gate_lo[k] = (leg_state[k] == ON_L);
    end
    fault_latched = fault_latched_q;
  end

endmodule

// File: tb/tb_dead_time_gen.sv
// Directed bench for dead_time_gen: cycle-by-cycle vector table, hand-written
// fault/enable sequences, then a randomized overlap and dead-time interval check.
module tb_dead_time_gen;

  localparam int N_LEGS = 6;
  localparam int DT_W   = 8;

  logic              clk;
  logic              rst;
  logic              en;
  logic              fault;
  logic              fault_clr;
  logic [DT_W-1:0]   dt_cycles;
  logic [N_LEGS-1:0] cmd;
  logic [N_LEGS-1:0] gate_hi;
  logic [N_LEGS-1:0] gate_lo;
  logic              fault_latched;

  int n_checks;
  int n_fail;

  typedef struct {
    logic              rst;
    logic              en;
    logic              fault;
    logic              clr;
    logic [DT_W-1:0]   dt;
    logic [N_LEGS-1:0] cmd;
    logic [N_LEGS-1:0] exp_hi;
    logic [N_LEGS-1:0] exp_lo;
    logic              exp_fl;
  } vec_t;

  vec_t vecs[$];

  dead_time_gen #(
    .N_LEGS(N_LEGS),
    .DT_W  (DT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .fault        (fault),
    .fault_clr    (fault_clr),
    .dt_cycles    (dt_cycles),
    .cmd          (cmd),
    .gate_hi      (gate_hi),
    .gate_lo      (gate_lo),
    .fault_latched(fault_latched)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench still running at time %0t, required finish earlier", $time);
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // driver tasks
  task automatic add(input int n, input logic r, input logic e, input logic f,
                     input logic c, input logic [DT_W-1:0] dt,
                     input logic [N_LEGS-1:0] cm, input logic [N_LEGS-1:0] hi,
                     input logic [N_LEGS-1:0] lo, input logic fl);
    vec_t v;
    v.rst = r; v.en = e; v.fault = f; v.clr = c; v.dt = dt; v.cmd = cm;
    v.exp_hi = hi; v.exp_lo = lo; v.exp_fl = fl;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic addn(input int n, input logic [DT_W-1:0] dt,
                      input logic [N_LEGS-1:0] cm, input logic [N_LEGS-1:0] hi,
                      input logic [N_LEGS-1:0] lo);
    add(n, 1'b0, 1'b1, 1'b0, 1'b0, dt, cm, hi, lo, 1'b0);
  endtask

  task automatic step(input logic r, input logic e, input logic f, input logic c,
                      input logic [DT_W-1:0] dt, input logic [N_LEGS-1:0] cm);
    rst = r; en = e; fault = f; fault_clr = c; dt_cycles = dt; cmd = cm;
    @(posedge clk);
    #1;
  endtask

  // scoreboard compare
  task automatic check(input string name, input logic [N_LEGS-1:0] hi,
                       input logic [N_LEGS-1:0] lo, input logic fl);
    n_checks++;
    if (gate_hi !== hi || gate_lo !== lo || fault_latched !== fl) begin
      n_fail++;
      $display("FAIL %s: got hi=%h lo=%h fl=%b, required hi=%h lo=%h fl=%b",
               name, gate_hi, gate_lo, fault_latched, hi, lo, fl);
    end
  endtask

  int off_cnt [N_LEGS];
  int min_d   [N_LEGS];
  logic [N_LEGS-1:0] prev_hi, prev_lo;

  initial begin
    rst = 1'b1; en = 1'b1; fault = 1'b0; fault_clr = 1'b0;
    dt_cycles = 8'd10; cmd = 6'h3F;
    n_checks = 0; n_fail = 0;

    // reset, then start-up honours a full dead time of 10
    add(3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd10, 6'h3F, 6'h00, 6'h00, 1'b0);
    addn(10, 8'd10, 6'h3F, 6'h00, 6'h00);
    addn(1,  8'd10, 6'h3F, 6'h3F, 6'h00);
    // leg0 high->low then low->high with dt=10
    addn(10, 8'd10, 6'h3E, 6'h3E, 6'h00);
    addn(1,  8'd10, 6'h3E, 6'h3E, 6'h01);
    addn(10, 8'd10, 6'h3F, 6'h3E, 6'h00);
    addn(1,  8'd10, 6'h3F, 6'h3F, 6'h00);
    // dt=0 behaves as one cycle
    addn(1, 8'd0, 6'h3E, 6'h3E, 6'h00);
    addn(1, 8'd0, 6'h3E, 6'h3E, 6'h01);
    addn(1, 8'd0, 6'h3F, 6'h3E, 6'h00);
    addn(1, 8'd0, 6'h3F, 6'h3F, 6'h00);
    // short low pulse restarts the window; low side never turns on
    addn(3,  8'd10, 6'h3E, 6'h3E, 6'h00);
    addn(10, 8'd10, 6'h3F, 6'h3E, 6'h00);
    addn(1,  8'd10, 6'h3F, 6'h3F, 6'h00);
    // dt captured only at window entry (3), later change to 10 ignored
    addn(1,  8'd3,  6'h3E, 6'h3E, 6'h00);
    addn(2,  8'd10, 6'h3E, 6'h3E, 6'h00);
    addn(1,  8'd10, 6'h3E, 6'h3E, 6'h01);
    addn(10, 8'd10, 6'h3F, 6'h3E, 6'h00);
    addn(1,  8'd10, 6'h3F, 6'h3F, 6'h00);
    // leg5 alone, dt=2
    addn(2, 8'd2, 6'h1F, 6'h1F, 6'h00);
    addn(1, 8'd2, 6'h1F, 6'h1F, 6'h20);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].fault, vecs[i].clr, vecs[i].dt, vecs[i].cmd);
      check($sformatf("vec%0d", i), vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_fl);
    end

    // fault arrives with leg1 inside its dead-time window
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 6'h1D);
    check("mix_pre0", 6'h1D, 6'h20, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 6'h1D);
    check("mix_pre1", 6'h1D, 6'h20, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'd4, 6'h1D);
    check("fault_set_beats_clr", 6'h00, 6'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 6'h1D);
      check("fault_hold", 6'h00, 6'h00, 1'b1);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'd4, 6'h1D);
    check("clr_with_fault", 6'h00, 6'h00, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'd4, 6'h1D);
    check("fault_clr", 6'h00, 6'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 6'h1D);
      check("fault_resume_dt", 6'h00, 6'h00, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 6'h1D);
    check("fault_resume", 6'h1D, 6'h22, 1'b0);

    // en drop is not latched; restart with full dead time
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 6'h1D);
    check("en_low", 6'h00, 6'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 6'h1D);
      check("en_resume_dt", 6'h00, 6'h00, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 6'h1D);
    check("en_resume", 6'h1D, 6'h22, 1'b0);

    // randomized: no overlap, and each turn-on preceded by >= D off cycles
    prev_hi = gate_hi;
    prev_lo = gate_lo;
    for (int k = 0; k < N_LEGS; k++) begin
      off_cnt[k] = 0;
      min_d[k]   = 255;
    end
    for (int c = 0; c < 4000; c++) begin
      logic [DT_W-1:0]   dt_r;
      logic [N_LEGS-1:0] cmd_r;
      logic              en_r;
      int                d_eff;
      dt_r  = dt_cycles;
      cmd_r = cmd;
      if ($urandom_range(0, 31) == 0) dt_r = DT_W'($urandom_range(0, 6));
      for (int k = 0; k < N_LEGS; k++)
        if ($urandom_range(0, 7) == 0) cmd_r[k] = ~cmd_r[k];
      en_r  = ($urandom_range(0, 15) != 0);
      d_eff = (dt_r == 0) ? 1 : int'(dt_r);
      step(1'b0, en_r, 1'b0, 1'b0, dt_r, cmd_r);
      for (int k = 0; k < N_LEGS; k++) begin
        n_checks++;
        if (gate_hi[k] && gate_lo[k]) begin
          n_fail++;
          $display("FAIL overlap leg%0d cycle%0d: got hi=1 lo=1, required not both", k, c);
        end
        if (!gate_hi[k] && !gate_lo[k]) begin
          off_cnt[k]++;
          if (d_eff < min_d[k]) min_d[k] = d_eff;
        end else begin
          if ((gate_hi[k] && !prev_hi[k]) || (gate_lo[k] && !prev_lo[k])) begin
            n_checks++;
            if (off_cnt[k] < min_d[k]) begin
              n_fail++;
              $display("FAIL dead_time leg%0d cycle%0d: got off=%0d cycles, required >= %0d",
                       k, c, off_cnt[k], min_d[k]);
            end
          end
          off_cnt[k] = 0;
          min_d[k]   = 255;
        end
      end
      prev_hi = gate_hi;
      prev_lo = gate_lo;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
